// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 arrow-key tracker.
//   - Scancode byte constants (Set-2 prefixes and extended arrow codes)
//   - Key index constants giving the bit order of held/press/release
//   - Parser state enum
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_DOWN  = 8'h72;
  localparam logic [7:0] PS2_RIGHT = 8'h74;
  localparam logic [7:0] PS2_UP    = 8'h75;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_RIGHT = 2;
  localparam int KEY_UP    = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    EXT_BRK = 2'd2,
    BRK     = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_arrow_code_lut.sv
// ps2_arrow_code_lut: purely combinational decode of a scancode byte into a
// one-hot arrow-key vector. Whether the byte was preceded by E0 is the
// caller's concern; this block only recognises the four code values.
// Ports:
//   i_byte   in  8  scancode byte
//   o_onehot out 4  one-hot key (bit order from KEY_* constants), 0 on miss
//   o_hit    out 1  byte is one of the four arrow codes
module ps2_arrow_code_lut
  import ps2_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [3:0] o_onehot,
  output logic       o_hit
);

  // Byte-to-key decode
  always_comb begin
    o_onehot = 4'b0000;
    o_hit    = 1'b0;
    case (i_byte)
      PS2_LEFT: begin
        o_onehot[KEY_LEFT] = 1'b1;
        o_hit              = 1'b1;
      end
      PS2_DOWN: begin
        o_onehot[KEY_DOWN] = 1'b1;
        o_hit              = 1'b1;
      end
      PS2_RIGHT: begin
        o_onehot[KEY_RIGHT] = 1'b1;
        o_hit               = 1'b1;
      end
      PS2_UP: begin
        o_onehot[KEY_UP] = 1'b1;
        o_hit            = 1'b1;
      end
      default: begin
        o_onehot = 4'b0000;
        o_hit    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ps2_arrow_tracker.sv
// ps2_arrow_tracker: parses a PS/2 Set-2 scancode byte stream (E0 extended
// and F0 break prefixes) and tracks the held state of the four arrow keys.
// Ports:
//   clk          in  1  system clock, rising edge
//   areset_n     in  1  asynchronous active-low reset
//   byte_in      in  8  scancode byte
//   byte_valid   in  1  byte_in accepted this cycle (no backpressure)
//   clear        in  1  synchronous flush of held state and parser
//   held         out 4  key currently down (0 left, 1 down, 2 right, 3 up)
//   press        out 4  one-cycle pulse on key going down
//   key_release  out 4  one-cycle pulse on key going up ("release" is a
//                       reserved word in SystemVerilog, hence the name)
//   seq_error    out 1  one-cycle pulse when a partial sequence times out
// All outputs are registered.
module ps2_arrow_tracker
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
)(
  input  logic       clk,
  input  logic       areset_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       clear,
  output logic [3:0] held,
  output logic [3:0] press,
  output logic [3:0] key_release,
  output logic       seq_error
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  // The abort fires on the idle cycle that would bring the counter to
  // TIMEOUT_CYCLES, so compare against one less.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e      r_state, w_state_nxt;
  logic [TO_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]      r_held, w_held_nxt;
  logic [3:0]      r_press, w_press_nxt;
  logic [3:0]      r_release, w_release_nxt;
  logic            r_seq_error, w_seq_error_nxt;
  logic [3:0]      w_key_onehot;
  logic            w_key_hit;

  ps2_arrow_code_lut u_lut (
    .i_byte   (byte_in),
    .o_onehot (w_key_onehot),
    .o_hit    (w_key_hit)
  );

  // State, counter and output registers
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_held      <= 4'b0000;
      r_press     <= 4'b0000;
      r_release   <= 4'b0000;
      r_seq_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_held      <= w_held_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_seq_error <= w_seq_error_nxt;
    end
  end

  // Next-state, held update, pulses and timeout counter
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_held_nxt      = r_held;
    w_press_nxt     = 4'b0000;
    w_release_nxt   = 4'b0000;
    w_seq_error_nxt = 1'b0;
    if (clear) begin
      // Flush silently; a same-cycle byte is dropped.
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_held_nxt  = 4'b0000;
    end else if (byte_valid) begin
      // An accepted byte always wins over a coincident timeout.
      w_cnt_nxt = '0;
      case (r_state)
        IDLE: begin
          if (byte_in == PS2_EXT) begin
            w_state_nxt = EXT;
          end else if (byte_in == PS2_BRK) begin
            w_state_nxt = BRK;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        EXT: begin
          if (byte_in == PS2_BRK) begin
            w_state_nxt = EXT_BRK;
          end else if (byte_in == PS2_EXT) begin
            w_state_nxt = EXT;
          end else if (w_key_hit) begin
            // Masking with ~r_held suppresses typematic repeats.
            w_held_nxt  = r_held | w_key_onehot;
            w_press_nxt = w_key_onehot & ~r_held;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        EXT_BRK: begin
          if (w_key_hit) begin
            w_held_nxt    = r_held & ~w_key_onehot;
            w_release_nxt = w_key_onehot & r_held;
          end else begin
            w_held_nxt = r_held;
          end
          w_state_nxt = IDLE;
        end
        BRK: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end else if (r_state != IDLE) begin
      if (r_cnt == TO_LAST) begin
        w_state_nxt     = IDLE;
        w_cnt_nxt       = '0;
        w_seq_error_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + TO_W'(1);
      end
    end else begin
      w_cnt_nxt = '0;
    end
  end

  assign held        = r_held;
  assign press       = r_press;
  assign key_release = r_release;
  assign seq_error   = r_seq_error;

endmodule

// File: tb/tb_ps2_arrow_tracker.sv
module tb_ps2_arrow_tracker;

  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       areset_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       clear;
  logic [3:0] held, press, key_release;
  logic       seq_error;

  ps2_arrow_tracker #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .areset_n    (areset_n),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .clear       (clear),
    .held        (held),
    .press       (press),
    .key_release (key_release),
    .seq_error   (seq_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] held;
    logic [3:0] press;
    logic [3:0] rel;
    logic       err;
  } exp_t;

  typedef struct {
    logic       v;
    logic [7:0] b;
    logic       c;
    exp_t       e;
    string      name;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic v, input logic [7:0] b, input logic c,
                              input logic [3:0] h, input logic [3:0] p,
                              input logic [3:0] r, input logic e, input string nm);
    vec_t x;
    x.v = v; x.b = b; x.c = c;
    x.e.held = h; x.e.press = p; x.e.rel = r; x.e.err = e;
    x.name = nm;
    return x;
  endfunction

  task automatic compare(input exp_t e, input string nm);
    exp_t a;
    a = {held, press, key_release, seq_error};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got held=%b press=%b release=%b err=%b, expected held=%b press=%b release=%b err=%b",
               nm, a.held, a.press, a.rel, a.err, e.held, e.press, e.rel, e.err);
    end
  endtask

  // Drive one cycle of input, queue the expected post-edge outputs, then
  // pop and compare once the registered outputs have settled.
  task automatic step(input logic v, input logic [7:0] b, input logic c,
                      input logic [3:0] h, input logic [3:0] p,
                      input logic [3:0] r, input logic e, input string nm);
    exp_t x;
    x = {h, p, r, e};
    byte_valid = v; byte_in = b; clear = c;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    compare(sb_q.pop_front(), nm);
    byte_valid = 1'b0; clear = 1'b0; byte_in = 8'h00;
  endtask

  initial begin
    areset_n = 1'b0; byte_valid = 1'b0; clear = 1'b0; byte_in = 8'h00;

    // Main vector table: {valid, byte, clear, held, press, release, err}
    tbl.push_back(mk(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "up_e0"));
    tbl.push_back(mk(1'b1, 8'h75, 1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b0, "up_make"));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, "up_press_ends"));
    tbl.push_back(mk(1'b1, 8'hF0, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, "kp_brk_f0"));
    tbl.push_back(mk(1'b1, 8'h75, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, "kp_brk_75_ignored"));
    tbl.push_back(mk(1'b1, 8'hE0, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, "up_brk_e0"));
    tbl.push_back(mk(1'b1, 8'hF0, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, "up_brk_f0"));
    tbl.push_back(mk(1'b1, 8'h75, 1'b0, 4'b0000, 4'b0000, 4'b1000, 1'b0, "up_break"));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "up_release_ends"));
    tbl.push_back(mk(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "left_e0"));
    tbl.push_back(mk(1'b1, 8'h6B, 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, "left_make"));
    tbl.push_back(mk(1'b1, 8'hE0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, "left_rep_e0"));
    tbl.push_back(mk(1'b1, 8'h6B, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, "left_repeat_no_press"));
    tbl.push_back(mk(1'b1, 8'hE0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, "left_brk_e0"));
    tbl.push_back(mk(1'b1, 8'hF0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, "left_brk_f0"));
    tbl.push_back(mk(1'b1, 8'h6B, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, "left_break"));
    tbl.push_back(mk(1'b1, 8'h72, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "kp_72_make"));
    tbl.push_back(mk(1'b1, 8'hF0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "kp_72_f0"));
    tbl.push_back(mk(1'b1, 8'h72, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "kp_72_break"));
    tbl.push_back(mk(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "down_e0"));
    tbl.push_back(mk(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "down_e0_again"));
    tbl.push_back(mk(1'b1, 8'h72, 1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b0, "down_make"));
    tbl.push_back(mk(1'b1, 8'hE0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, "extbrk_e0"));
    tbl.push_back(mk(1'b1, 8'hF0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, "extbrk_f0"));
    tbl.push_back(mk(1'b1, 8'hE0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, "extbrk_e0_aborts"));
    tbl.push_back(mk(1'b1, 8'h72, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, "idle_72_ignored"));
    tbl.push_back(mk(1'b1, 8'hE0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, "down_brk_e0"));
    tbl.push_back(mk(1'b1, 8'hF0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, "down_brk_f0"));
    tbl.push_back(mk(1'b1, 8'h72, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, "down_break"));
    tbl.push_back(mk(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "right_brk_e0"));
    tbl.push_back(mk(1'b1, 8'hF0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "right_brk_f0"));
    tbl.push_back(mk(1'b1, 8'h74, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "right_break_not_held"));
    tbl.push_back(mk(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "other_e0"));
    tbl.push_back(mk(1'b1, 8'h11, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "other_byte_to_idle"));
    tbl.push_back(mk(1'b1, 8'h74, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "bare_74_ignored"));

    // Reset state, checked while reset is still asserted
    #12;
    compare('0, "reset_state");
    areset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].v, tbl[i].b, tbl[i].c, tbl[i].e.held, tbl[i].e.press,
           tbl[i].e.rel, tbl[i].e.err, tbl[i].name);

    // Timeout: E0 then TO idle cycles; seq_error on the TO-th idle cycle only
    step(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "to_e0");
    for (int i = 1; i < TO; i++)
      step(1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "to_wait");
    step(1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, "to_seq_error");
    step(1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "to_err_one_cycle");
    step(1'b1, 8'h74, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "to_then_74_ignored");

    // Byte arriving on exactly the timeout cycle wins
    step(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "race_e0");
    for (int i = 1; i < TO; i++)
      step(1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "race_wait");
    step(1'b1, 8'h74, 1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0, "race_byte_wins");

    // Clear with same-cycle E0: silent flush, byte dropped
    step(1'b1, 8'hE0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, "clr_up_e0");
    step(1'b1, 8'h75, 1'b0, 4'b1100, 4'b1000, 4'b0000, 1'b0, "clr_up_make");
    step(1'b1, 8'hE0, 1'b0, 4'b1100, 4'b0000, 4'b0000, 1'b0, "clr_left_e0");
    step(1'b1, 8'h6B, 1'b0, 4'b1101, 4'b0001, 4'b0000, 1'b0, "clr_left_make");
    step(1'b1, 8'hE0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "clear_flush");
    step(1'b1, 8'h75, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "clear_dropped_e0");

    // Async reset mid-sequence
    step(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "rst_right_e0");
    step(1'b1, 8'h74, 1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0, "rst_right_make");
    step(1'b1, 8'hE0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, "rst_brk_e0");
    step(1'b1, 8'hF0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, "rst_brk_f0");
    areset_n = 1'b0;
    #1;
    compare('0, "async_reset");
    #2;
    areset_n = 1'b1;
    step(1'b1, 8'h75, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "post_reset_75");
    step(1'b1, 8'h74, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "post_reset_74");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_arrow_tracker.md
Name: ps2_arrow_tracker

Overview:
Byte-stream successor to the 16-bit arrow-scancode decoder. It consumes PS/2 Set-2 scancode bytes one at a time, parses the E0 (extended) and F0 (break) prefixes with an FSM, and tracks the held state of the four arrow keys. It emits registered held levels plus one-cycle press/release pulses. It sits between the PS/2 byte receiver and game logic.

Parameters:
TIMEOUT_CYCLES, 1000, idle cycles allowed between bytes of a multi-byte sequence before it is aborted (must be >= 2)
TO_W, $clog2(TIMEOUT_CYCLES+1), localparam; width of the timeout counter

Ports:
clk  in  1  system clock, all state on rising edge
areset_n  in  1  asynchronous active-low reset
byte_in  in  8  scancode byte from the PS/2 receiver
byte_valid  in  1  byte_in is accepted on any cycle where this is high; no backpressure
clear  in  1  synchronous flush of held state and parser
held  out  4  level, key currently down; bit 0 left, 1 down, 2 right, 3 up
press  out  4  one-cycle pulse on a not-held to held transition; same bit order
release  out  4  one-cycle pulse on a held to not-held transition; same bit order
seq_error  out  1  one-cycle pulse when a partial sequence is aborted by timeout

Behaviour:
- Reset (areset_n low): held=0, press=0, release=0, seq_error=0, FSM=IDLE, timeout counter=0. Takes effect immediately, regardless of clock.
- All outputs are registered. Pulses assert in the cycle after the completing byte is accepted.
- Arrow codes, valid only after E0: 6B left, 72 down, 74 right, 75 up. Non-extended 6B/72/74/75 are keypad keys and must not affect the arrow state.
- FSM states and transitions on an accepted byte:
  - IDLE: E0 goes to EXT. F0 goes to BRK. Any other byte stays in IDLE with no effect.
  - EXT: F0 goes to EXT_BRK. E0 stays in EXT. An arrow code sets held[k] and returns to IDLE. Any other byte returns to IDLE with no effect.
  - EXT_BRK: an arrow code clears held[k] and returns to IDLE. Any other byte (including E0/F0) returns to IDLE with no effect.
  - BRK: any byte returns to IDLE with no effect (non-extended release consumed).
- Typematic repeat: a make for an already-held key leaves held unchanged and produces no press pulse. A break for a non-held key produces no release pulse.
- Timeout: in any non-IDLE state, the counter increments on each cycle without byte_valid and resets to 0 on an accepted byte. When it reaches TIMEOUT_CYCLES: FSM goes to IDLE, counter=0, seq_error pulses once. held is unchanged.
- Simultaneous timeout and byte_valid: the byte wins. It is processed normally and there is no seq_error.
- The counter holds at 0 in IDLE.
- clear: on the next edge, held=0, FSM=IDLE, counter=0. No release pulses are generated. clear overrides a same-cycle byte_valid, which is dropped.
- press, release and seq_error are 0 on every cycle not described above.
- At most one bit of press or release is set in any cycle.

Decomposition:
- Shared package ps2_pkg contains:
  - byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_LEFT=8'h6B, PS2_DOWN=8'h72, PS2_RIGHT=8'h74, PS2_UP=8'h75
  - key index constants KEY_LEFT=0, KEY_DOWN=1, KEY_RIGHT=2, KEY_UP=3
  - 2-bit state enum {IDLE, EXT, EXT_BRK, BRK}
- One sub-module: ps2_arrow_code_lut, purely combinational: byte to 4-bit one-hot plus hit. Inside it, every output gets a default value before the case so no latch is inferred.

Test Plan:
- Reset then E0,75 -> held=4'b1000 one cycle after 75; press=4'b1000 for exactly one cycle; release=0.
- E0,6B, then E0,6B again, then E0,F0,6B -> a single press[0] pulse; no pulse on the repeat; release[0] pulse after the final 6B; held returns to 0.
- Non-extended 72, then F0,72 -> held stays 0; press, release and seq_error never assert; FSM ends in IDLE.
- E0, then TIMEOUT_CYCLES idle cycles (default 1000) -> seq_error pulses once at cycle 1000; a following 74 alone does not set held.
- E0 followed by 74 arriving on exactly the timeout cycle -> held[2]=1, press[2] pulses, no seq_error.
- Hold up and left, then assert clear with a same-cycle E0 -> held=0, no release pulses, FSM in IDLE. Also: deassert areset_n mid-sequence (after E0,F0) -> all outputs 0 asynchronously; a subsequent 75 sets nothing.
